// File: rtl/ita_hwpe_job_sequencer.sv
// ita_hwpe_job_sequencer: queues committed ITA jobs, sequences the optional
// weight preload, launches the four streamers plus the engine and collects
// their completion pulses, raising one done event per job.
module ita_hwpe_job_sequencer #(
  parameter int unsigned N_CONTEXT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       job_valid_i,
  output logic       job_ready_o,
  input  logic [4:0] job_ctrl_i,
  output logic [4:0] ctrl_o,
  output logic       input_start_o,
  output logic       weight_start_o,
  output logic       bias_start_o,
  output logic       output_start_o,
  output logic       engine_start_o,
  input  logic       input_done_i,
  input  logic       weight_done_i,
  input  logic       bias_done_i,
  input  logic       output_done_i,
  input  logic       engine_done_i,
  output logic       evt_done_o,
  output logic       busy_o,
  output logic [1:0] state_o
);

  localparam int unsigned PTR_W = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
  localparam int unsigned CNT_W = $clog2(N_CONTEXT + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CONTEXT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_CONTEXT);

  // ctrl bit positions
  localparam int unsigned CB_WPRE  = 0;
  localparam int unsigned CB_WNEXT = 1;
  localparam int unsigned CB_BDIS  = 2;
  localparam int unsigned CB_ODIS  = 4;

  // per-source index shared by start pulses and sticky done flags
  localparam int unsigned D_IN = 0;
  localparam int unsigned D_WT = 1;
  localparam int unsigned D_BI = 2;
  localparam int unsigned D_OU = 3;
  localparam int unsigned D_EN = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       ctrl_q, ctrl_d;
  logic [4:0]       flags_q, flags_d;
  logic [4:0]       start_q, start_d;
  logic             preloaded_q, preloaded_d;
  logic             evt_q, evt_d;

  logic [4:0]       fifo_q [N_CONTEXT];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             push_s, pop_s, enter_run_s, complete_s;
  logic [4:0]       head_s, hits_s, run_ctrl_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Ready reflects pre-pop occupancy, so a full queue refuses a push even when
  // the same cycle pops.
  assign job_ready_o = (cnt_q != CNT_FULL);
  assign busy_o      = (state_q != ST_IDLE) || (cnt_q != {CNT_W{1'b0}});
  assign push_s      = job_valid_i & job_ready_o & ~clear_i;
  assign head_s      = fifo_q[rd_ptr_q];

  // Done pulses seen so far plus this cycle's; disabled sources never count.
  assign hits_s = flags_q | {engine_done_i,
                             output_done_i & ~ctrl_q[CB_ODIS],
                             bias_done_i   & ~ctrl_q[CB_BDIS],
                             weight_done_i &  ctrl_q[CB_WNEXT],
                             input_done_i};

  assign complete_s = hits_s[D_IN] & hits_s[D_EN]
                    & (ctrl_q[CB_BDIS]   | hits_s[D_BI])
                    & (ctrl_q[CB_ODIS]   | hits_s[D_OU])
                    & (~ctrl_q[CB_WNEXT] | hits_s[D_WT]);

  // Next-state, pop decision and registered-output values for the job FSM.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    flags_d     = flags_q;
    preloaded_d = preloaded_q;
    start_d     = 5'b00000;
    evt_d       = 1'b0;
    pop_s       = 1'b0;
    enter_run_s = 1'b0;
    run_ctrl_s  = ctrl_q;

    case (state_q)
      ST_IDLE: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          pop_s       = 1'b1;
          ctrl_d      = head_s;
          // the skip decision uses the old flag, then the flag is consumed
          preloaded_d = 1'b0;
          if (head_s[CB_WPRE] && !preloaded_q) begin
            state_d       = ST_PRELOAD;
            start_d[D_WT] = 1'b1;
          end else begin
            state_d     = ST_RUN;
            enter_run_s = 1'b1;
            run_ctrl_s  = head_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRELOAD: begin
        if (weight_done_i) begin
          state_d     = ST_RUN;
          enter_run_s = 1'b1;
        end else begin
          state_d = ST_PRELOAD;
        end
      end
      ST_RUN: begin
        flags_d = hits_s;
        if (weight_done_i && ctrl_q[CB_WNEXT]) begin
          preloaded_d = 1'b1;
        end else begin
          preloaded_d = preloaded_q;
        end
        if (complete_s) begin
          state_d = ST_DONE;
          evt_d   = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_run_s) begin
      flags_d       = 5'b00000;
      start_d[D_IN] = 1'b1;
      start_d[D_EN] = 1'b1;
      start_d[D_BI] = ~run_ctrl_s[CB_BDIS];
      start_d[D_OU] = ~run_ctrl_s[CB_ODIS];
      start_d[D_WT] = run_ctrl_s[CB_WNEXT];
    end else begin
      start_d = start_d;
    end

    // soft clear wins over every transition
    if (clear_i) begin
      state_d     = ST_IDLE;
      ctrl_d      = 5'b00000;
      flags_d     = 5'b00000;
      preloaded_d = 1'b0;
      start_d     = 5'b00000;
      evt_d       = 1'b0;
      pop_s       = 1'b0;
    end else begin
      pop_s = pop_s;
    end
  end

  // FSM state and registered job outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= 5'b00000;
      flags_q     <= 5'b00000;
      start_q     <= 5'b00000;
      preloaded_q <= 1'b0;
      evt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      flags_q     <= flags_d;
      start_q     <= start_d;
      preloaded_q <= preloaded_d;
      evt_q       <= evt_d;
    end
  end

  // Job queue storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CONTEXT; i++) begin
        fifo_q[i] <= 5'b00000;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= job_ctrl_i;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_s && !pop_s) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (!push_s && pop_s) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign ctrl_o         = ctrl_q;
  assign input_start_o  = start_q[D_IN];
  assign weight_start_o = start_q[D_WT];
  assign bias_start_o   = start_q[D_BI];
  assign output_start_o = start_q[D_OU];
  assign engine_start_o = start_q[D_EN];
  assign evt_done_o     = evt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_ita_hwpe_job_sequencer.sv
// Bench for ita_hwpe_job_sequencer: directed scenarios followed by randomized
// jobs, all checked against a job-level model (queue of ctrl words, a
// preloaded flag and per-job completion time from the done delays).
module tb_ita_hwpe_job_sequencer;

  localparam int N_CTX = 2;

  logic       clk;
  logic       rst_i, clear_i, job_valid_i, job_ready_o;
  logic [4:0] job_ctrl_i, ctrl_o;
  logic       input_start_o, weight_start_o, bias_start_o, output_start_o, engine_start_o;
  logic       input_done_i, weight_done_i, bias_done_i, output_done_i, engine_done_i;
  logic       evt_done_o, busy_o;
  logic [1:0] state_o;

  int vectors;
  int miscompares;

  logic [4:0] q_m[$];
  logic       pre_m;

  ita_hwpe_job_sequencer #(.N_CONTEXT(N_CTX)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_ctrl_i(job_ctrl_i),
    .ctrl_o(ctrl_o),
    .input_start_o(input_start_o), .weight_start_o(weight_start_o),
    .bias_start_o(bias_start_o), .output_start_o(output_start_o),
    .engine_start_o(engine_start_o),
    .input_done_i(input_done_i), .weight_done_i(weight_done_i),
    .bias_done_i(bias_done_i), .output_done_i(output_done_i),
    .engine_done_i(engine_done_i),
    .evt_done_o(evt_done_o), .busy_o(busy_o), .state_o(state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dones();
    input_done_i = 1'b0; weight_done_i = 1'b0; bias_done_i = 1'b0;
    output_done_i = 1'b0; engine_done_i = 1'b0;
  endtask

  function automatic logic [4:0] starts();
    return {input_start_o, weight_start_o, bias_start_o, output_start_o, engine_start_o};
  endfunction

  task automatic chk_idle_empty(input string tag);
    chk({tag, "_state"}, state_o, 2'd0);
    chk({tag, "_ctrl"}, ctrl_o, 5'd0);
    chk({tag, "_starts"}, starts(), 5'd0);
    chk({tag, "_evt"}, evt_done_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_ready"}, job_ready_o, 1'b1);
  endtask

  // Push in the current cycle (DUT expected IDLE with nothing to pop yet).
  task automatic push(input logic [4:0] v);
    job_valid_i = 1'b1;
    job_ctrl_i  = v;
    chk("push_ready", job_ready_o, (q_m.size() < N_CTX));
    if (q_m.size() < N_CTX) q_m.push_back(v);
    cyc();
    job_valid_i = 1'b0;
    job_ctrl_i  = 5'd0;
  endtask

  // Runs the job at the queue head from its IDLE pop cycle back to IDLE.
  // Delays are cycle offsets from the first PRELOAD / first RUN cycle.
  task automatic exec_job(input int dl_pre, input int d_in, input int d_wt,
                          input int d_bi, input int d_ou, input int d_en,
                          input int n_push, input bit push_rand,
                          input logic [4:0] push_val);
    logic [4:0] c;
    logic [4:0] pv;
    int t_done;
    chk("idle_state", state_o, 2'd0);
    chk("idle_busy", busy_o, 1'b1);
    chk("idle_ready", job_ready_o, (q_m.size() < N_CTX));
    c = q_m.pop_front();
    cyc();
    if (c[0] && !pre_m) begin
      for (int k = 0; k <= dl_pre; k++) begin
        chk("pre_state", state_o, 2'd1);
        chk("pre_ctrl", ctrl_o, c);
        chk("pre_starts", starts(), (k == 0) ? 5'b01000 : 5'b00000);
        weight_done_i = (k == dl_pre);
        cyc();
        weight_done_i = 1'b0;
      end
    end
    pre_m = 1'b0;
    t_done = (d_in > d_en) ? d_in : d_en;
    if (n_push > t_done) t_done = n_push;
    if (!c[2] && d_bi > t_done) t_done = d_bi;
    if (!c[4] && d_ou > t_done) t_done = d_ou;
    if (c[1] && d_wt > t_done) t_done = d_wt;
    for (int k = 0; k <= t_done; k++) begin
      chk("run_state", state_o, 2'd2);
      chk("run_ctrl", ctrl_o, c);
      chk("run_evt", evt_done_o, 1'b0);
      chk("run_starts", starts(),
          (k == 0) ? {1'b1, c[1], ~c[2], ~c[4], 1'b1} : 5'b00000);
      input_done_i  = (k == d_in);
      engine_done_i = (k == d_en);
      bias_done_i   = c[2] ? 1'($urandom_range(0, 1)) : (k == d_bi);
      output_done_i = c[4] ? 1'($urandom_range(0, 1)) : (k == d_ou);
      weight_done_i = c[1] ? (k == d_wt) : 1'($urandom_range(0, 1));
      if (k < n_push) begin
        pv = push_rand ? 5'($urandom) : push_val;
        job_valid_i = 1'b1;
        job_ctrl_i  = pv;
        chk("run_push_ready", job_ready_o, (q_m.size() < N_CTX));
        if (q_m.size() < N_CTX) q_m.push_back(pv);
      end
      cyc();
      clr_dones();
      job_valid_i = 1'b0;
      job_ctrl_i  = 5'd0;
    end
    if (c[1]) pre_m = 1'b1;
    chk("done_state", state_o, 2'd3);
    chk("done_evt", evt_done_o, 1'b1);
    chk("done_starts", starts(), 5'd0);
    {input_done_i, weight_done_i, bias_done_i, output_done_i, engine_done_i} = 5'($urandom);
    cyc();
    clr_dones();
    chk("post_state", state_o, 2'd0);
    chk("post_evt", evt_done_o, 1'b0);
    chk("post_busy", busy_o, (q_m.size() != 0));
  endtask

  initial begin
    vectors = 0; miscompares = 0; pre_m = 1'b0;
    rst_i = 1'b1; clear_i = 1'b0; job_valid_i = 1'b0; job_ctrl_i = 5'd0;
    clr_dones();
    repeat (2) cyc();
    chk_idle_empty("rst");
    rst_i = 1'b0;
    cyc();
    chk_idle_empty("rst_rel");

    // minimal job: dones at +3/+5/+7/+4 from push = RUN offsets 1/3/5/2
    push(5'b00000);
    exec_job(0, 1, 0, 3, 5, 2, 0, 1'b0, 5'd0);

    // weight preload, RUN one cycle after weight_done
    push(5'b00001);
    exec_job(3, 1, 0, 0, 2, 0, 0, 1'b0, 5'd0);

    // nextload on A waits for weight_done; B skips PRELOAD
    push(5'b00010);
    exec_job(0, 0, 4, 1, 0, 1, 1, 1'b0, 5'b00001);
    exec_job(0, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0);

    // bias/output disabled, input+engine together
    push(5'b10100);
    exec_job(0, 2, 0, 0, 0, 2, 0, 1'b0, 5'd0);

    // queue full while RUN stalls: third push refused
    push(5'b00000);
    exec_job(0, 5, 0, 1, 2, 3, 3, 1'b0, 5'b10100);
    exec_job(0, 1, 0, 0, 0, 1, 0, 1'b0, 5'd0);
    exec_job(0, 0, 0, 0, 0, 2, 0, 1'b0, 5'd0);

    // clear mid-RUN with one job queued and preloaded set
    job_valid_i = 1'b1; job_ctrl_i = 5'b00010;
    cyc();
    job_ctrl_i = 5'b00001;
    cyc();
    job_valid_i = 1'b0; job_ctrl_i = 5'd0;
    chk("clr_run_state", state_o, 2'd2);
    weight_done_i = 1'b1;
    cyc();
    weight_done_i = 1'b0;
    chk("clr_run_state2", state_o, 2'd2);
    clear_i = 1'b1; job_valid_i = 1'b1; job_ctrl_i = 5'b00000;
    input_done_i = 1'b1; engine_done_i = 1'b1;
    cyc();
    clear_i = 1'b0; job_valid_i = 1'b0; clr_dones();
    chk_idle_empty("clr");
    for (int k = 0; k < 3; k++) begin
      input_done_i = 1'b1; engine_done_i = 1'b1; weight_done_i = 1'b1;
      cyc();
      clr_dones();
      chk("clr_after_state", state_o, 2'd0);
      chk("clr_after_evt", evt_done_o, 1'b0);
    end
    q_m.delete();
    pre_m = 1'b0;
    push(5'b00001);
    exec_job(1, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0);

    // asynchronous reset mid-RUN with one job queued
    push(5'b00000);
    cyc();
    chk("rst_run_state", state_o, 2'd2);
    job_valid_i = 1'b1; job_ctrl_i = 5'b00000;
    cyc();
    job_valid_i = 1'b0;
    #3 rst_i = 1'b1;
    #1;
    chk_idle_empty("arst");
    #1 rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      input_done_i = 1'b1; engine_done_i = 1'b1; bias_done_i = 1'b1; output_done_i = 1'b1;
      chk("arst_after_state", state_o, 2'd0);
      chk("arst_after_evt", evt_done_o, 1'b0);
    end
    cyc();
    clr_dones();
    q_m.delete();
    pre_m = 1'b0;

    // randomized jobs
    for (int j = 0; j < 40; j++) begin
      if (q_m.size() == 0) push(5'($urandom));
      exec_job($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 2), 1'b1, 5'd0);
    end
    while (q_m.size() != 0) begin
      exec_job(0, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b1, 5'd0);
    end
    chk("final_busy", busy_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
